// File: rtl/vector_writeback.sv
// Drains CHANNEL_NUM (row_id, value) FIFOs into a sectioned result RAM.
// A free-running section counter sweeps the RAM. Each channel's head pops
// only when its row_id section equals the counter. One masked section write
// is issued the cycle after the pops.
//
// Ports:
//   clk, rst       clock; synchronous active-low reset
//   row_id         FWFT heads, channel c at [c*ROW_ID_SIZE +: ROW_ID_SIZE]
//   row_val        FWFT head values, channel c at [c*VAL_BITS +: VAL_BITS]
//   in_empty       per-channel FIFO empty
//   in_read        per-channel pop, combinational
//   flush, done    drain request / drained-and-idle indication (registered)
//   ram_addr       section address (registered)
//   ram_we         write strobe (registered)
//   ram_wmask      one bit per written element (registered)
//   ram_wdata      element e at [e*VAL_BITS +: VAL_BITS]
//   ram_rdata      section read at the counter, valid one cycle later
//
// Build option: define ACCUMULATE_EN to add incoming values onto ram_rdata
// instead of overwriting; colliding channels then all pop together.
module vector_writeback #(
  parameter int CHANNEL_NUM  = 4,
  parameter int ROW_ID_SIZE  = 10,
  parameter int VAL_BITS     = 8,
  parameter int COUNTER_BITS = 3,
  parameter int SECTION_NUM  = 8,
  localparam int EB = ROW_ID_SIZE - COUNTER_BITS,
  localparam int SEC_ELEMS = 2**EB
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CHANNEL_NUM*ROW_ID_SIZE-1:0] row_id,
  input  logic [CHANNEL_NUM*VAL_BITS-1:0] row_val,
  input  logic [CHANNEL_NUM-1:0]          in_empty,
  output logic [CHANNEL_NUM-1:0]          in_read,
  input  logic                            flush,
  output logic                            done,
  output logic [COUNTER_BITS-1:0]         ram_addr,
  output logic                            ram_we,
  output logic [SEC_ELEMS-1:0]            ram_wmask,
  output logic [SEC_ELEMS*VAL_BITS-1:0]   ram_wdata,
  input  logic [SEC_ELEMS*VAL_BITS-1:0]   ram_rdata
);

  localparam logic [COUNTER_BITS-1:0] CNT_LAST =
    COUNTER_BITS'(SECTION_NUM - 1);

  logic [COUNTER_BITS-1:0] cnt;
  logic [CHANNEL_NUM-1:0]  match;
  logic [CHANNEL_NUM-1:0]  pop;
  logic [EB-1:0]           elem [CHANNEL_NUM];
  logic [VAL_BITS-1:0]     val  [CHANNEL_NUM];

  logic [SEC_ELEMS-1:0]          nxt_mask;
  logic [SEC_ELEMS*VAL_BITS-1:0] nxt_data;
  logic [SEC_ELEMS*VAL_BITS-1:0] wdata_q;

  always_comb begin
    match = '0;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      elem[c]  = row_id[c*ROW_ID_SIZE +: EB];
      val[c]   = row_val[c*VAL_BITS +: VAL_BITS];
      match[c] = !in_empty[c] &&
        (row_id[c*ROW_ID_SIZE+EB +: COUNTER_BITS] == cnt);
    end
  end

`ifdef ACCUMULATE_EN
  always_comb begin
    pop = match;
  end
`else
  // A channel yields to any lower-index matching channel aiming at the
  // same element; it retries on the next sweep.
  always_comb begin
    pop = '0;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      pop[c] = match[c];
      for (int j = 0; j < c; j++) begin
        if (match[j] && (elem[j] == elem[c])) begin
          pop[c] = 1'b0;
        end
      end
    end
  end
`endif

  assign in_read = rst ? pop : '0;

  // Summing into zeroed slots: with unique winners this is a plain
  // overwrite, with accumulation it merges colliding channels.
  always_comb begin
    nxt_mask = '0;
    nxt_data = '0;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      if (pop[c]) begin
        nxt_mask[elem[c]] = 1'b1;
        nxt_data[elem[c]*VAL_BITS +: VAL_BITS] =
          nxt_data[elem[c]*VAL_BITS +: VAL_BITS] + val[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= '0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wmask <= '0;
      wdata_q   <= '0;
      done      <= 1'b0;
    end else begin
      cnt       <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      ram_addr  <= cnt;
      ram_we    <= |pop;
      ram_wmask <= nxt_mask;
      wdata_q   <= nxt_data;
      done      <= flush & (&in_empty) & ~ram_we;
    end
  end

`ifdef ACCUMULATE_EN
  // rdata for the staged section arrives now; add it in unregistered.
  for (genvar e = 0; e < SEC_ELEMS; e++) begin : g_acc
    assign ram_wdata[e*VAL_BITS +: VAL_BITS] = ram_wmask[e] ?
      wdata_q[e*VAL_BITS +: VAL_BITS] +
      ram_rdata[e*VAL_BITS +: VAL_BITS] : '0;
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^ram_rdata;
  assign ram_wdata = wdata_q;
`endif

endmodule

// File: tb/tb_vector_writeback.sv
// Randomized self-checking bench for vector_writeback (overwrite build).
// Queue-based FIFO/RAM-write reference model plus directed scenarios.
module tb_vector_writeback;

  localparam int CH = 4;
  localparam int NS = 8;

  typedef struct packed {
    logic [9:0] id;
    logic [7:0] v;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [39:0]   row_id;
  logic [31:0]   row_val;
  logic [3:0]    in_empty;
  logic [3:0]    in_read;
  logic          flush;
  logic          done;
  logic [2:0]    ram_addr;
  logic          ram_we;
  logic [127:0]  ram_wmask;
  logic [1023:0] ram_wdata;
  logic [1023:0] ram_rdata;

  vector_writeback dut (
    .clk(clk), .rst(rst),
    .row_id(row_id), .row_val(row_val),
    .in_empty(in_empty), .in_read(in_read),
    .flush(flush), .done(done),
    .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wmask(ram_wmask), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  ent_t q [CH][$];

  int           cnt_m = 0;
  logic         exp_we = 1'b0;
  logic [2:0]   exp_addr = '0;
  logic [127:0] exp_mask = '0;
  logic [7:0]   exp_slot [128];
  logic         exp_done = 1'b0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < CH; c++) begin
      if (q[c].size() > 0) begin
        row_id[c*10 +: 10] = q[c][0].id;
        row_val[c*8 +: 8]  = q[c][0].v;
        in_empty[c]        = 1'b0;
      end else begin
        row_id[c*10 +: 10] = 10'($urandom);
        row_val[c*8 +: 8]  = 8'($urandom);
        in_empty[c]        = 1'b1;
      end
    end
  endtask

  // One clock: check at negedge, advance model at posedge, redrive.
  task automatic step();
    logic [3:0]   pm;
    logic [127:0] claimed;
    logic [127:0] nmask;
    logic [7:0]   nslot [128];
    logic         all_empty;
    int           sec;
    int           el;
    pm = '0;
    claimed = '0;
    nmask = '0;
    for (int e = 0; e < 128; e++) nslot[e] = '0;
    all_empty = 1'b1;
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      if (q[c].size() > 0) begin
        all_empty = 1'b0;
        sec = int'(q[c][0].id) / 128;
        el  = int'(q[c][0].id) % 128;
        if (rst && sec == cnt_m && !claimed[el]) begin
          claimed[el] = 1'b1;
          pm[c] = 1'b1;
          nmask[el] = 1'b1;
          nslot[el] = q[c][0].v;
        end
      end
    end
    chk("in_read", 128'(in_read), 128'(pm));
    chk("ram_we", 128'(ram_we), 128'(exp_we));
    chk("ram_addr", 128'(ram_addr), 128'(exp_addr));
    chk("ram_wmask", ram_wmask, exp_mask);
    chk("done", 128'(done), 128'(exp_done));
    if (exp_we || ram_we) begin
      for (int e = 0; e < 128; e++)
        chk($sformatf("wdata[%0d]", e),
            128'(ram_wdata[e*8 +: 8]), 128'(exp_slot[e]));
    end else begin
      chk("wdata_zero", 128'(|ram_wdata), 128'(0));
    end
    @(posedge clk);
    if (!rst) begin
      cnt_m = 0;
      exp_we = 1'b0;
      exp_addr = '0;
      exp_mask = '0;
      for (int e = 0; e < 128; e++) exp_slot[e] = '0;
      exp_done = 1'b0;
    end else begin
      exp_done = flush && all_empty && !exp_we;
      exp_we = |pm;
      exp_addr = 3'(cnt_m);
      exp_mask = nmask;
      for (int e = 0; e < 128; e++) exp_slot[e] = nslot[e];
      for (int c = 0; c < CH; c++)
        if (pm[c]) void'(q[c].pop_front());
      cnt_m = (cnt_m + 1) % NS;
    end
    #1;
    drive();
  endtask

  task automatic push(input int c, input int id, input int v);
    ent_t e;
    e.id = 10'(id);
    e.v  = 8'(v);
    q[c].push_back(e);
  endtask

  int n;
  int n0;

  initial begin
    for (int e = 0; e < 128; e++) exp_slot[e] = '0;
    rst = 1'b0;
    flush = 1'b0;
    ram_rdata = '1;
    push(0, 'h085, 'h5A);
    push(3, 'h2C3, 'h77);
    drive();

    // Reset held with non-empty FIFOs.
    repeat (3) step();
    chk("rst_in_read", 128'(in_read), 128'(0));
    chk("rst_we", 128'(ram_we), 128'(0));
    chk("rst_mask", ram_wmask, 128'(0));
    chk("rst_done", 128'(done), 128'(0));

    // Single write: pops at counter 1, lands next cycle.
    rst = 1'b1;
    step();
    step();
    chk("single_we", 128'(ram_we), 128'(1));
    chk("single_addr", 128'(ram_addr), 128'(1));
    chk("single_mask", ram_wmask, 128'(1) << 5);
    chk("single_slot5", 128'(ram_wdata[5*8 +: 8]), 128'('h5A));

    // Wrap: section 0 entry presented at counter 2 waits for 7->0.
    push(1, 'h000, 'h33);
    drive();
    n = 0;
    while (q[1].size() > 0 && n < 20) begin
      step();
      n++;
    end
    chk("wrap_latency", 128'(n), 128'(7));

    // Collision: ch2 trails ch0 by exactly one sweep.
    while (q[3].size() > 0 && n < 40) begin
      step();
      n++;
    end
    push(0, 'h3FF, 'h10);
    push(2, 'h3FF, 'h20);
    drive();
    n = 0;
    while (q[0].size() > 0 && n < 20) begin
      step();
      n++;
    end
    chk("coll_first_slot", 128'(ram_wdata[127*8 +: 8]), 128'('h10));
    n0 = n;
    while (q[2].size() > 0 && n < 40) begin
      step();
      n++;
    end
    chk("coll_gap", 128'(n - n0), 128'(8));
    chk("coll_second_slot", 128'(ram_wdata[127*8 +: 8]), 128'('h20));

    // Multi: four distinct elements in section 2, one write.
    for (int c = 0; c < CH; c++) push(c, 'h100 + c, 'hA0 + c);
    drive();
    n = 0;
    while (q[0].size() > 0 && n < 20) begin
      step();
      n++;
    end
    chk("multi_queues", 128'(q[1].size() + q[2].size() + q[3].size()), 128'(0));
    chk("multi_addr", 128'(ram_addr), 128'(2));
    chk("multi_mask", ram_wmask, 128'('hF));
    for (int c = 0; c < CH; c++)
      chk("multi_slot", 128'(ram_wdata[c*8 +: 8]), 128'('hA0 + c));

    // Flush with three entries queued.
    push(0, 'h2A1, 1);
    push(1, 'h052, 2);
    push(2, 'h3C3, 3);
    flush = 1'b1;
    drive();
    n = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    chk("flush_done", 128'(done), 128'(1));
    flush = 1'b0;
    step();
    step();
    chk("flush_drop", 128'(done), 128'(0));

    // Randomized bursts with drain windows and one mid-run reset.
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 150; i++) begin
        if (i < 100) begin
          for (int c = 0; c < CH; c++) begin
            if (q[c].size() < 4 && $urandom_range(9) < 3) begin
              if ($urandom_range(1) == 1)
                push(c, 'h300 + $urandom_range(3), $urandom);
              else
                push(c, $urandom_range(1023), $urandom);
            end
          end
          flush = ($urandom_range(7) == 0);
        end else begin
          flush = 1'b1;
        end
        rst = !(b == 2 && (i == 50 || i == 51));
        drive();
        step();
      end
    end
    rst = 1'b1;
    flush = 1'b0;
    drive();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
